// File: rtl/serial_byte_tx.sv
// UART-style transmitter: pulls one byte at a time from the upstream FIFO and
// shifts it out LSB-first as start, data, optional parity and stop bits.
module serial_byte_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EMPTY_N,
  input  logic [DATA_WIDTH-1:0] D_IN,
  output logic                  DEQ,
  output logic                  TXD,
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
  logic [IDX_W-1:0]      bit_idx, bit_idx_next;
  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic                  parity_bit, parity_next;
  logic                  txd_q, txd_next;
  logic                  busy_q;
  logic                  deq_req;

  // Every register's next value is decided here; TXD is computed one cycle
  // ahead so the line itself comes straight from a flop.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    parity_next  = parity_bit;
    txd_next     = txd_q;
    deq_req      = 1'b0;

    case (state)
      S_IDLE: begin
        txd_next = 1'b1;
        if (EMPTY_N) begin
          deq_req      = 1'b1;
          state_next   = S_START;
          bit_cnt_next = CNT_MAX;
          shift_next   = D_IN;
          parity_next  = (PARITY == 1) ? ~^D_IN : ^D_IN;
          txd_next     = 1'b0;
        end
      end
      S_START: begin
        if (bit_cnt == '0) begin
          state_next   = S_DATA;
          bit_cnt_next = CNT_MAX;
          bit_idx_next = '0;
          txd_next     = shift[0];
        end else begin
          bit_cnt_next = bit_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (bit_cnt == '0) begin
          bit_cnt_next = CNT_MAX;
          if (bit_idx == LAST_DATA) begin
            bit_idx_next = '0;
            if (PARITY != 0) begin
              state_next = S_PARITY;
              txd_next   = parity_bit;
            end else begin
              state_next = S_STOP;
              txd_next   = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            shift_next   = {1'b0, shift[DATA_WIDTH-1:1]};
            txd_next     = shift[1];
          end
        end else begin
          bit_cnt_next = bit_cnt - 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_cnt == '0) begin
          state_next   = S_STOP;
          bit_cnt_next = CNT_MAX;
          bit_idx_next = '0;
          txd_next     = 1'b1;
        end else begin
          bit_cnt_next = bit_cnt - 1'b1;
        end
      end
      S_STOP: begin
        txd_next = 1'b1;
        if (bit_cnt == '0) begin
          bit_cnt_next = CNT_MAX;
          if (bit_idx == LAST_STOP) begin
            state_next   = S_IDLE;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt - 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  // Reset drops any partial frame and returns the line to idle-high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      parity_bit <= parity_next;
      txd_q      <= txd_next;
      busy_q     <= (state_next != S_IDLE);
    end
  end

  assign DEQ  = deq_req && !RST;
  assign TXD  = txd_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Bench for serial_byte_tx: three configurations (no parity, even parity,
// odd parity with two stop bits) checked by hand tables and a line-level model.
module tb_serial_byte_tx;

  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       empty_n [3];
  logic [7:0] d_in    [3];
  logic       deq     [3];
  logic       txd     [3];
  logic       busy    [3];

  int n_pass  = 0;
  int n_total = 0;
  bit model_on = 1'b0;

  always #5 CLK = ~CLK;

  serial_byte_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut_none (
    .CLK(CLK), .RST(RST), .EMPTY_N(empty_n[0]), .D_IN(d_in[0]),
    .DEQ(deq[0]), .TXD(txd[0]), .BUSY(busy[0]));

  serial_byte_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut_even (
    .CLK(CLK), .RST(RST), .EMPTY_N(empty_n[1]), .D_IN(d_in[1]),
    .DEQ(deq[1]), .TXD(txd[1]), .BUSY(busy[1]));

  serial_byte_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut_odd (
    .CLK(CLK), .RST(RST), .EMPTY_N(empty_n[2]), .D_IN(d_in[2]),
    .DEQ(deq[2]), .TXD(txd[2]), .BUSY(busy[2]));

  typedef struct {
    int          unit;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] bits;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  // Expected line levels per unit, one entry per clock, front = current cycle.
  bit q0[$];
  bit q1[$];
  bit q2[$];

  function automatic int par_of(input int u);
    return (u == 0) ? 0 : (u == 1) ? 2 : 1;
  endfunction

  function automatic int stop_of(input int u);
    return (u == 2) ? 2 : 1;
  endfunction

  function automatic int model_size(input int u);
    case (u)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic bit model_front(input int u);
    case (u)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic model_push(input int u, input bit b);
    case (u)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic model_pop(input int u);
    bit dummy;
    case (u)
      0:       dummy = q0.pop_front();
      1:       dummy = q1.pop_front();
      default: dummy = q2.pop_front();
    endcase
  endtask

  task automatic model_clear(input int u);
    case (u)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic model_frame(input int u, input logic [7:0] d);
    bit lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(d[i]);
    if (par_of(u) == 2) lv.push_back(^d);
    else if (par_of(u) == 1) lv.push_back(~^d);
    for (int s = 0; s < stop_of(u); s++) lv.push_back(1'b1);
    foreach (lv[i]) repeat (CPB) model_push(u, lv[i]);
  endtask

  task automatic model_step(input int u);
    bit idle;
    bit e_deq;
    bit e_txd;
    idle  = (model_size(u) == 0);
    e_txd = idle ? 1'b1 : model_front(u);
    e_deq = idle && empty_n[u] && !RST;
    check($sformatf("model_txd[%0d]", u), txd[u], e_txd);
    check($sformatf("model_busy[%0d]", u), busy[u], !idle);
    check($sformatf("model_deq[%0d]", u), deq[u], e_deq);
    check($sformatf("deq_without_data[%0d]", u), deq[u] && !empty_n[u], 1'b0);
    if (RST) model_clear(u);
    else begin
      if (!idle) model_pop(u);
      if (e_deq) model_frame(u, d_in[u]);
    end
  endtask

  always @(negedge CLK) begin
    if (model_on) for (int u = 0; u < 3; u++) model_step(u);
  end

  task automatic present(input int u, input logic [7:0] d);
    @(posedge CLK);
    #1;
    empty_n[u] = 1'b1;
    d_in[u]    = d;
  endtask

  task automatic wait_deq(input int u, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (deq[u]) seen = 1'b1;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic track_frame(input int vi, input bit scramble);
    int u;
    u = vecs[vi].unit;
    for (int k = 0; k < vecs[vi].nbits; k++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge CLK);
        check($sformatf("v%0d_bit%0d_txd", vi, k), txd[u], vecs[vi].bits[k]);
        check($sformatf("v%0d_bit%0d_busy", vi, k), busy[u], 1'b1);
        if (scramble) d_in[u] = 8'($urandom);
      end
    end
  endtask

  task automatic check_idle(input int u, input string name);
    @(negedge CLK);
    check({name, "_txd"}, txd[u], 1'b1);
    check({name, "_busy"}, busy[u], 1'b0);
    check({name, "_deq"}, deq[u], 1'b0);
  endtask

  task automatic send_vec(input int vi, input bit scramble);
    int u;
    u = vecs[vi].unit;
    present(u, vecs[vi].data);
    wait_deq(u, $sformatf("v%0d_deq", vi));
    @(posedge CLK);
    #1;
    empty_n[u] = 1'b0;
    track_frame(vi, scramble);
    check_idle(u, $sformatf("v%0d_after", vi));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1;
    for (int u = 0; u < 3; u++) begin
      empty_n[u] = 1'b0;
      d_in[u]    = 8'h00;
    end

    // Transmitted bit sequences, index 0 first on the line.
    vecs[0] = '{0, 8'hA5, 10, 12'b00_1101001010};
    vecs[1] = '{1, 8'h07, 11, 12'b0_11000001110};
    vecs[2] = '{2, 8'h07, 12, 12'b110000001110};
    vecs[3] = '{1, 8'h3C, 11, 12'b0_10001111000};
    vecs[4] = '{2, 8'hB2, 12, 12'b111101100100};
    vecs[5] = '{0, 8'h00, 10, 12'b00_1000000000};
    vecs[6] = '{0, 8'hFF, 10, 12'b00_1111111110};
    vecs[7] = '{0, 8'h55, 10, 12'b00_1010101010};

    @(posedge CLK);
    #1;
    model_on = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    repeat (50) begin
      @(negedge CLK);
      for (int u = 0; u < 3; u++) begin
        check($sformatf("idle_txd[%0d]", u), txd[u], 1'b1);
        check($sformatf("idle_deq[%0d]", u), deq[u], 1'b0);
        check($sformatf("idle_busy[%0d]", u), busy[u], 1'b0);
      end
    end

    for (int i = 0; i < 5; i++) send_vec(i, i >= 3);

    present(0, 8'h00);
    wait_deq(0, "b2b_deq1");
    @(posedge CLK);
    #1;
    d_in[0] = 8'hFF;
    track_frame(5, 1'b0);
    @(negedge CLK);
    check("b2b_gap_txd", txd[0], 1'b1);
    check("b2b_gap_busy", busy[0], 1'b0);
    check("b2b_deq2_at_41", deq[0], 1'b1);
    @(posedge CLK);
    #1;
    empty_n[0] = 1'b0;
    track_frame(6, 1'b0);
    check_idle(0, "b2b_end");

    present(0, 8'h55);
    wait_deq(0, "rst_deq");
    @(posedge CLK);
    #1;
    empty_n[0] = 1'b0;
    for (int n = 0; n < 17; n++) begin
      @(negedge CLK);
      check($sformatf("rst_pre_txd%0d", n), txd[0], vecs[7].bits[n / CPB]);
    end
    @(posedge CLK);
    #1;
    RST        = 1'b1;
    empty_n[0] = 1'b1;
    d_in[0]    = 8'hA5;
    @(negedge CLK);
    check("rst_cycle_no_deq", deq[0], 1'b0);
    check("rst_cycle_txd", txd[0], vecs[7].bits[4]);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_after_txd", txd[0], 1'b1);
    check("rst_after_busy", busy[0], 1'b0);
    check("rst_after_deq", deq[0], 1'b1);
    @(posedge CLK);
    #1;
    empty_n[0] = 1'b0;
    track_frame(0, 1'b0);
    check_idle(0, "rst_next_end");

    repeat (1500) begin
      @(posedge CLK);
      #1;
      RST = ($urandom_range(0, 149) == 0);
      for (int u = 0; u < 3; u++) begin
        empty_n[u] = ($urandom_range(0, 3) != 0);
        d_in[u]    = 8'($urandom);
      end
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int u = 0; u < 3; u++) empty_n[u] = 1'b0;
    repeat (60) @(posedge CLK);
    @(negedge CLK);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("drain_busy[%0d]", u), busy[u], 1'b0);
      check($sformatf("drain_txd[%0d]", u), txd[u], 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
